// File: rtl/val2_shifter_pipe_if.sv
// rtl/val2_shifter_pipe_if.sv - Upstream/downstream handshake bundle for the val2 shifter pipe
interface val2_shifter_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_rm_val;
    logic [WIDTH-1:0] in_rs_val;
    logic [11:0]      in_shifter_oprand;
    logic             in_imm;
    logic             in_mem_en;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_val2;
    logic             out_carry;

    modport master (
        output in_valid, in_rm_val, in_rs_val, in_shifter_oprand, in_imm, in_mem_en, in_carry,
        output out_ready,
        input  in_ready, out_valid, out_val2, out_carry
    );

    modport slave (
        input  in_valid, in_rm_val, in_rs_val, in_shifter_oprand, in_imm, in_mem_en, in_carry,
        input  out_ready,
        output in_ready, out_valid, out_val2, out_carry
    );
endinterface

// File: rtl/val2_shifter_pipe.sv
// rtl/val2_shifter_pipe.sv - Pipelined ARM operand-2 generator with shifter carry-out
module val2_shifter_pipe #(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 2,
    parameter bit MEM_SEXT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    val2_shifter_pipe_if.slave dif
);
    localparam int LW = $clog2(WIDTH);
    localparam int NB = (LW + 1 > 8) ? LW + 1 : 8;
    localparam logic [NB-1:0] W_N = NB'(WIDTH);

    localparam logic [1:0] T_LSL = 2'd0;
    localparam logic [1:0] T_LSR = 2'd1;
    localparam logic [1:0] T_ASR = 2'd2;
    localparam logic [1:0] T_ROR = 2'd3;

    typedef enum logic [2:0] {M_PASS, M_SHIFT, M_ZERO, M_FILL, M_RRX} mode_e;
    typedef enum logic [1:0] {CS_IN, CS_ZERO, CS_BIT, CS_RES_MSB} csrc_e;

    // Decoded beat: everything the shift stage needs, with amount edge cases resolved.
    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic [1:0]       typ;
        logic [LW-1:0]    k;
        mode_e            mode;
        csrc_e            csrc;
        logic [LW-1:0]    cidx;
        logic             c_in;
    } dec_t;

    dec_t             dec_d;
    dec_t             s2;
    logic [11:0]      op;
    logic [NB-1:0]    sh_n;
    logic [LW-1:0]    sh_k;
    logic             imm_zero;
    logic             unused_rs;

    assign unused_rs = ^dif.in_rs_val[WIDTH-1:8];

    always_comb begin
        op         = dif.in_shifter_oprand;
        sh_n       = '0;
        sh_k       = '0;
        imm_zero   = 1'b0;
        dec_d.val  = dif.in_rm_val;
        dec_d.typ  = op[6:5];
        dec_d.k    = '0;
        dec_d.mode = M_PASS;
        dec_d.csrc = CS_IN;
        dec_d.cidx = '0;
        dec_d.c_in = dif.in_carry;
        if (dif.in_mem_en) begin
            if (MEM_SEXT) dec_d.val = {{(WIDTH-12){op[11]}}, op};
            else          dec_d.val = {{(WIDTH-12){1'b0}}, op};
        end else if (dif.in_imm) begin
            dec_d.val  = {{(WIDTH-8){1'b0}}, op[7:0]};
            dec_d.typ  = T_ROR;
            dec_d.mode = M_SHIFT;
            dec_d.k    = LW'({op[11:8], 1'b0});
            dec_d.csrc = (op[11:8] == 4'd0) ? CS_IN : CS_RES_MSB;
        end else begin
            sh_n     = op[4] ? NB'(dif.in_rs_val[7:0]) : NB'(op[11:7]);
            imm_zero = !op[4] && (op[11:7] == 5'd0);
            if (imm_zero && (op[6:5] == T_LSR || op[6:5] == T_ASR)) sh_n = W_N;
            sh_k = sh_n[LW-1:0];
            if (imm_zero && op[6:5] == T_ROR) begin
                dec_d.mode = M_RRX;
                dec_d.csrc = CS_BIT;
            end else if (sh_n != '0) begin
                case (op[6:5])
                    T_LSL: begin
                        if (sh_n < W_N) begin
                            dec_d.mode = M_SHIFT;
                            dec_d.k    = sh_k;
                            dec_d.csrc = CS_BIT;
                            dec_d.cidx = -sh_k;
                        end else if (sh_n == W_N) begin
                            dec_d.mode = M_ZERO;
                            dec_d.csrc = CS_BIT;
                        end else begin
                            dec_d.mode = M_ZERO;
                            dec_d.csrc = CS_ZERO;
                        end
                    end
                    T_LSR: begin
                        if (sh_n < W_N) begin
                            dec_d.mode = M_SHIFT;
                            dec_d.k    = sh_k;
                            dec_d.csrc = CS_BIT;
                            dec_d.cidx = sh_k - LW'(1);
                        end else if (sh_n == W_N) begin
                            dec_d.mode = M_ZERO;
                            dec_d.csrc = CS_BIT;
                            dec_d.cidx = LW'(WIDTH - 1);
                        end else begin
                            dec_d.mode = M_ZERO;
                            dec_d.csrc = CS_ZERO;
                        end
                    end
                    T_ASR: begin
                        dec_d.csrc = CS_BIT;
                        if (sh_n < W_N) begin
                            dec_d.mode = M_SHIFT;
                            dec_d.k    = sh_k;
                            dec_d.cidx = sh_k - LW'(1);
                        end else begin
                            dec_d.mode = M_FILL;
                            dec_d.cidx = LW'(WIDTH - 1);
                        end
                    end
                    default: begin
                        dec_d.csrc = CS_BIT;
                        if (sh_k == '0) begin
                            dec_d.mode = M_PASS;
                            dec_d.cidx = LW'(WIDTH - 1);
                        end else begin
                            dec_d.mode = M_SHIFT;
                            dec_d.k    = sh_k;
                            dec_d.cidx = sh_k - LW'(1);
                        end
                    end
                endcase
            end
        end
    end

    logic [WIDTH-1:0] bs;
    logic [WIDTH-1:0] res;
    logic             res_c;

    // One barrel level per bit of the amount.
    always_comb begin
        bs = s2.val;
        for (int l = 0; l < LW; l++) begin
            if (s2.k[l]) begin
                case (s2.typ)
                    T_LSL:   bs = bs << (1 << l);
                    T_LSR:   bs = bs >> (1 << l);
                    T_ASR:   bs = $signed(bs) >>> (1 << l);
                    default: bs = (bs >> (1 << l)) | (bs << (WIDTH - (1 << l)));
                endcase
            end
        end
    end

    always_comb begin
        case (s2.mode)
            M_PASS:  res = s2.val;
            M_SHIFT: res = bs;
            M_FILL:  res = {WIDTH{s2.val[WIDTH-1]}};
            M_RRX:   res = {s2.c_in, s2.val[WIDTH-1:1]};
            default: res = '0;
        endcase
        case (s2.csrc)
            CS_IN:   res_c = s2.c_in;
            CS_BIT:  res_c = s2.val[s2.cidx];
            CS_RES_MSB: res_c = res[WIDTH-1];
            default: res_c = 1'b0;
        endcase
    end

    logic             out_valid_q;
    logic [WIDTH-1:0] out_val2_q;
    logic             out_carry_q;
    logic             out_load;
    logic             stage_valid;

    assign out_load = !out_valid_q || dif.out_ready;

    generate
        if (STAGES == 2) begin : g_two
            logic s1_valid_q;
            dec_t s1_q;

            assign dif.in_ready = rst_n && !flush && (!s1_valid_q || out_load);
            assign s2           = s1_q;
            assign stage_valid  = s1_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_q <= 1'b0;
                    s1_q       <= '0;
                end else if (flush) begin
                    s1_valid_q <= 1'b0;
                end else if (!s1_valid_q || out_load) begin
                    s1_valid_q <= dif.in_valid;
                    if (dif.in_valid) s1_q <= dec_d;
                end
            end
        end else begin : g_one
            assign dif.in_ready = rst_n && !flush && out_load;
            assign s2           = dec_d;
            assign stage_valid  = dif.in_valid && dif.in_ready;
        end
    endgenerate

    // Flush kills the output beat even if the consumer is taking it this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_val2_q  <= '0;
            out_carry_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (out_load) begin
            out_valid_q <= stage_valid;
            if (stage_valid) begin
                out_val2_q  <= res;
                out_carry_q <= res_c;
            end
        end
    end

    assign dif.out_valid = out_valid_q;
    assign dif.out_val2  = out_val2_q;
    assign dif.out_carry = out_carry_q;
endmodule

// File: tb/tb_val2_shifter_pipe.sv
// tb/tb_val2_shifter_pipe.sv - Self-checking bench for val2_shifter_pipe
module tb_val2_shifter_pipe;
    localparam int W  = 32;
    localparam int NV = 20;
    localparam int NR = 40;

    typedef struct {
        logic [31:0] rm;
        logic [31:0] rs;
        logic [11:0] op;
        logic        imm;
        logic        mem;
        logic        c;
        logic [31:0] ev;
        logic        ec;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    int   lat;
    int   pop_base;
    logic saw_full;

    always #5 clk = ~clk;

    val2_shifter_pipe_if #(.WIDTH(W)) dif ();
    val2_shifter_pipe_if #(.WIDTH(W)) dif1 ();

    val2_shifter_pipe #(.WIDTH(W), .STAGES(2), .MEM_SEXT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .dif(dif));
    val2_shifter_pipe #(.WIDTH(W), .STAGES(1), .MEM_SEXT(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .dif(dif1));

    logic [32:0] sb [$];
    vec_t tbl [NV];
    vec_t rnd [NR];
    vec_t bp  [6];

    function automatic logic [32:0] ref_model(input logic [31:0] rm, input logic [31:0] rs,
                                              input logic [11:0] op, input logic imm,
                                              input logic mem, input logic c, input logic sext);
        logic [31:0] v;
        logic [31:0] x;
        logic        co;
        int          n;
        int          k;
        v  = rm;
        co = c;
        if (mem) begin
            v = sext ? {{20{op[11]}}, op} : {20'h0, op};
        end else if (imm) begin
            x = {24'h0, op[7:0]};
            n = 2 * int'(op[11:8]);
            v = (x >> n) | (x << (32 - n));
            if (op[11:8] != 4'd0) co = v[31];
        end else begin
            n = op[4] ? int'(rs[7:0]) : int'(op[11:7]);
            if (!op[4] && op[11:7] == 5'd0) begin
                if (op[6:5] == 2'd3) return {c, rm[31:1], rm[0]};
                if (op[6:5] != 2'd0) n = 32;
            end
            if (n != 0) begin
                case (op[6:5])
                    2'd0: if (n < 32) begin v = rm << n; co = rm[32-n]; end
                          else if (n == 32) begin v = 0; co = rm[0]; end
                          else begin v = 0; co = 1'b0; end
                    2'd1: if (n < 32) begin v = rm >> n; co = rm[n-1]; end
                          else if (n == 32) begin v = 0; co = rm[31]; end
                          else begin v = 0; co = 1'b0; end
                    2'd2: if (n < 32) begin v = $signed(rm) >>> n; co = rm[n-1]; end
                          else begin v = {32{rm[31]}}; co = rm[31]; end
                    default: begin
                        k = n % 32;
                        if (k == 0) co = rm[31];
                        else begin v = (rm >> k) | (rm << (32 - k)); co = rm[k-1]; end
                    end
                endcase
            end
        end
        return {v, co};
    endfunction

    function automatic vec_t mkv(input logic [31:0] rm, input logic [31:0] rs, input logic [11:0] op,
                                 input logic imm, input logic mem, input logic c,
                                 input logic [31:0] ev, input logic ec);
        vec_t v;
        v.rm = rm; v.rs = rs; v.op = op; v.imm = imm; v.mem = mem; v.c = c; v.ev = ev; v.ec = ec;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t  v;
        logic [32:0] r;
        v.rm       = $urandom;
        v.rs       = $urandom;
        v.rs[7:0]  = 8'($urandom_range(0, 70));
        v.op       = 12'($urandom);
        v.imm      = ($urandom_range(0, 3) == 0);
        v.mem      = ($urandom_range(0, 7) == 0);
        v.c        = 1'($urandom);
        r          = ref_model(v.rm, v.rs, v.op, v.imm, v.mem, v.c, 1'b1);
        v.ev       = r[32:1];
        v.ec       = r[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        dif.in_rm_val         = v.rm;
        dif.in_rs_val         = v.rs;
        dif.in_shifter_oprand = v.op;
        dif.in_imm            = v.imm;
        dif.in_mem_en         = v.mem;
        dif.in_carry          = v.c;
    endtask

    task automatic send(input vec_t v);
        int tries = 0;
        drive(v);
        dif.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (dif.in_ready) begin
                sb.push_back({v.ev, v.ec});
                break;
            end
            tries++;
            if (tries > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", tries);
                break;
            end
        end
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic        prev_stall = 1'b0;
    logic [31:0] prev_v;
    logic        prev_c;
    logic [32:0] mon_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && dif.out_valid) begin
                checks++;
                if (dif.out_val2 !== prev_v || dif.out_carry !== prev_c) begin
                    errors++;
                    $display("FAIL stall_hold: val2=%h carry=%b required val2=%h carry=%b",
                             dif.out_val2, dif.out_carry, prev_v, prev_c);
                end
            end
            if (dif.out_valid && dif.out_ready && !flush) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: val2=%h carry=%b required no beat",
                             dif.out_val2, dif.out_carry);
                end else begin
                    mon_exp = sb.pop_front();
                    popped++;
                    if ({dif.out_val2, dif.out_carry} !== mon_exp) begin
                        errors++;
                        $display("FAIL result_%0d: val2=%h carry=%b required val2=%h carry=%b",
                                 popped, dif.out_val2, dif.out_carry, mon_exp[32:1], mon_exp[0]);
                    end
                end
            end
            prev_stall = dif.out_valid && !dif.out_ready;
            prev_v     = dif.out_val2;
            prev_c     = dif.out_carry;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mkv(32'h0,        32'h0,   12'h4FF, 1, 0, 0, 32'hFF000000, 1);
        tbl[1]  = mkv(32'h80000001, 32'h0,   12'h020, 0, 0, 0, 32'h00000000, 1);
        tbl[2]  = mkv(32'h80000000, 32'h0,   12'h040, 0, 0, 0, 32'hFFFFFFFF, 1);
        tbl[3]  = mkv(32'h00000003, 32'h0,   12'h060, 0, 0, 1, 32'h80000001, 1);
        tbl[4]  = mkv(32'h00000001, 32'd32,  12'h010, 0, 0, 0, 32'h00000000, 1);
        tbl[5]  = mkv(32'h00000001, 32'd33,  12'h010, 0, 0, 1, 32'h00000000, 0);
        tbl[6]  = mkv(32'h00000001, 32'h100, 12'h010, 0, 0, 1, 32'h00000001, 1);
        tbl[7]  = mkv(32'h00000001, 32'h100, 12'h010, 0, 0, 0, 32'h00000001, 0);
        tbl[8]  = mkv(32'h0000000F, 32'd36,  12'h070, 0, 0, 0, 32'hF0000000, 1);
        tbl[9]  = mkv(32'h00000000, 32'h0,   12'h800, 0, 1, 1, 32'hFFFFF800, 1);
        tbl[10] = mkv(32'hFFFFFFFF, 32'h0,   12'h800, 0, 1, 0, 32'hFFFFF800, 0);
        tbl[11] = mkv(32'h1000000F, 32'h0,   12'h200, 0, 0, 0, 32'h000000F0, 1);
        tbl[12] = mkv(32'h7FFFFFFF, 32'd40,  12'h050, 0, 0, 1, 32'h00000000, 0);
        tbl[13] = mkv(32'h80000000, 32'd32,  12'h030, 0, 0, 0, 32'h00000000, 1);
        tbl[14] = mkv(32'h00000000, 32'h0,   12'h0AB, 1, 0, 1, 32'h000000AB, 1);
        tbl[15] = mkv(32'h12345678, 32'h0,   12'h000, 0, 0, 0, 32'h12345678, 0);
        tbl[16] = mkv(32'h80000000, 32'd32,  12'h070, 0, 0, 0, 32'h80000000, 1);
        tbl[17] = mkv(32'h000000F8, 32'd4,   12'h030, 0, 0, 0, 32'h0000000F, 1);
        tbl[18] = mkv(32'h80000010, 32'h0,   12'h240, 0, 0, 1, 32'hF8000001, 0);
        tbl[19] = mkv(32'h12345678, 32'h0,   12'h460, 0, 0, 0, 32'h78123456, 0);
        for (int i = 0; i < NR; i++) rnd[i] = rand_vec();
        for (int i = 0; i < 6; i++) bp[i] = rand_vec();

        rst_n = 1'b0;
        flush = 1'b0;
        dif.in_valid = 1'b0;
        drive(tbl[0]);
        dif.out_ready = 1'b1;
        dif1.in_valid = 1'b0;
        dif1.in_rm_val = '0;
        dif1.in_rs_val = '0;
        dif1.in_shifter_oprand = '0;
        dif1.in_imm = 1'b0;
        dif1.in_mem_en = 1'b0;
        dif1.in_carry = 1'b0;
        dif1.out_ready = 1'b1;

        #12;
        check("reset_out_valid", 64'(dif.out_valid), 64'd0);
        check("reset_out_val2",  64'(dif.out_val2),  64'd0);
        check("reset_out_carry", 64'(dif.out_carry), 64'd0);
        check("reset_in_ready",  64'(dif.in_ready),  64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(dif.in_ready), 64'd1);
        @(posedge clk);
        #1;

        send(tbl[0]);
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dif.out_valid) break;
            @(posedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd2);
        @(posedge clk);
        #1;

        for (int i = 1; i < NV; i++) send(tbl[i]);
        for (int i = 0; i < NR; i++) send(rnd[i]);
        drain();

        pop_base = popped;
        saw_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(bp[i]);
            end
            begin
                for (int cyc = 1; cyc <= 10; cyc++) begin
                    dif.out_ready = !(cyc >= 3 && cyc <= 6);
                    @(negedge clk);
                    if (dif.in_valid && !dif.in_ready) saw_full = 1'b1;
                    @(posedge clk);
                    #1;
                end
                dif.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_beats_out", 64'(popped - pop_base), 64'd6);
        check("bp_in_ready_drop", 64'(saw_full), 64'd1);

        dif.out_ready = 1'b0;
        send(tbl[1]);
        send(tbl[2]);
        flush = 1'b1;
        dif.out_ready = 1'b1;
        drive(tbl[3]);
        dif.in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(dif.in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        dif.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("flush_out_valid", 64'(dif.out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_no_late_beat", 64'(dif.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        dif.out_ready = 1'b0;
        send(tbl[8]);
        send(tbl[9]);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(dif.out_valid), 64'd0);
        check("midreset_out_val2",  64'(dif.out_val2),  64'd0);
        check("midreset_out_carry", 64'(dif.out_carry), 64'd0);
        check("midreset_in_ready",  64'(dif.in_ready),  64'd0);
        sb.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dif.out_ready = 1'b1;
        @(negedge clk);
        check("ready_after_midreset", 64'(dif.in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(tbl[3]);
        send(tbl[18]);
        drain();

        dif1.in_mem_en = 1'b1;
        dif1.in_shifter_oprand = 12'h800;
        dif1.in_carry = 1'b0;
        dif1.in_valid = 1'b1;
        @(negedge clk);
        check("s1_in_ready", 64'(dif1.in_ready), 64'd1);
        check("s1_idle_out_valid", 64'(dif1.out_valid), 64'd0);
        @(posedge clk);
        #1;
        dif1.in_shifter_oprand = 12'h7FF;
        dif1.in_carry = 1'b1;
        @(negedge clk);
        check("s1_latency_valid", 64'(dif1.out_valid), 64'd1);
        check("s1_mem_zext_val2", 64'(dif1.out_val2), 64'h00000800);
        check("s1_mem_carry0",    64'(dif1.out_carry), 64'd0);
        @(posedge clk);
        #1;
        dif1.in_valid = 1'b0;
        @(negedge clk);
        check("s1_second_valid", 64'(dif1.out_valid), 64'd1);
        check("s1_second_val2",  64'(dif1.out_val2), 64'h000007FF);
        check("s1_second_carry", 64'(dif1.out_carry), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("s1_empty_after", 64'(dif1.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
